// File: rtl/addsub_pkg.sv
// Shared types and defaults for the bit-serial adder/subtractor.
package addsub_pkg;

  localparam int ADDSUB_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/addsub8_serial_fa.sv
// Combinational 1-bit full adder, the only arithmetic cell in the serial loop.
module full_adder1 (
  input  logic A,
  input  logic B,
  input  logic CI,
  output logic S,
  output logic CO
);

  assign S  = A ^ B ^ CI;
  assign CO = (A & B) | (A & CI) | (B & CI);

endmodule

// File: rtl/addsub8_serial.sv
// Bit-serial two's-complement add/subtract, LSB first, one full-adder cell.
// Define ADDSUB8_SERIAL_OVF_EN to add the OVF port and signed-overflow logic.
module addsub8_serial
  import addsub_pkg::*;
#(
  parameter int WIDTH = ADDSUB_WIDTH_DEFAULT
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             I_VALID,
  output logic             I_READY,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic             SUB,
  input  logic             CIN,
  output logic             O_VALID,
  input  logic             O_READY,
  output logic [WIDTH-1:0] O,
  output logic             COUT
`ifdef ADDSUB8_SERIAL_OVF_EN
  ,
  output logic             OVF
`endif
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             fa_s, fa_co;
`ifdef ADDSUB8_SERIAL_OVF_EN
  logic             prev_carry_q, prev_carry_d;
`endif

  // Operands shift right each BUSY cycle, so the adder always sees bit 0.
  full_adder1 u_fa (
    .A  (a_q[0]),
    .B  (b_q[0]),
    .CI (carry_q),
    .S  (fa_s),
    .CO (fa_co)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef ADDSUB8_SERIAL_OVF_EN
    prev_carry_d = prev_carry_q;
`endif
    case (state_q)
      IDLE: begin
        if (I_VALID) begin
          a_d     = I0;
          b_d     = SUB ? ~I1 : I1;
          carry_d = SUB ? 1'b1 : CIN;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        res_d   = {fa_s, res_q[WIDTH-1:1]};
        carry_d = fa_co;
        if (cnt_q == LAST) begin
          cout_d  = fa_co;
`ifdef ADDSUB8_SERIAL_OVF_EN
          prev_carry_d = carry_q;
`endif
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (O_READY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef ADDSUB8_SERIAL_OVF_EN
      prev_carry_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
`ifdef ADDSUB8_SERIAL_OVF_EN
      prev_carry_q <= prev_carry_d;
`endif
    end
  end

  assign I_READY = (state_q == IDLE) && !RESET;
  assign O_VALID = (state_q == DONE);
  assign O       = res_q;
  assign COUT    = cout_q;
`ifdef ADDSUB8_SERIAL_OVF_EN
  assign OVF     = prev_carry_q ^ cout_q;
`endif

endmodule

// File: tb/tb_addsub8_serial.sv
// Self-checking bench for addsub8_serial: directed vectors, backpressure,
// mid-operation reset and 1000 random operations against an arithmetic model.
module tb_addsub8_serial;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RESET, I_VALID, I_READY, SUB, CIN;
  logic         O_VALID, O_READY, COUT, OVF;
  logic [W-1:0] I0, I1, O;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  addsub8_serial #(.WIDTH(W)) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .I_VALID (I_VALID),
    .I_READY (I_READY),
    .I0      (I0),
    .I1      (I1),
    .SUB     (SUB),
    .CIN     (CIN),
    .O_VALID (O_VALID),
    .O_READY (O_READY),
    .O       (O),
    .COUT    (COUT)
`ifdef ADDSUB8_SERIAL_OVF_EN
    ,
    .OVF     (OVF)
`endif
  );

`ifndef ADDSUB8_SERIAL_OVF_EN
  assign OVF = 1'b0;
`endif

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic       cin;
    logic [7:0] o;
    logic       co;
    logic       ov;
  } vec_t;

  vec_t vecs[7];

  task automatic chk1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, got, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                input logic sub, input logic cin,
                                output logic [7:0] o, output logic co, output logic ov);
    int ua, ub, sa, sb, ur, sr;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      ur = ua - ub;
      sr = sa - sb;
      co = (ua >= ub);
    end else begin
      ur = ua + ub + int'(cin);
      sr = sa + sb + int'(cin);
      co = (ur > 255);
    end
    o  = 8'(ur);
    ov = (sr < -128) || (sr > 127);
  endfunction

  task automatic scramble();
    I0      = 8'($urandom);
    I1      = 8'($urandom);
    SUB     = 1'($urandom);
    CIN     = 1'($urandom);
    I_VALID = 1'($urandom);
    O_READY = 1'($urandom);
  endtask

  // One operation: issue, wait for the result, hold it for `hold` cycles, release.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic s, input logic c,
                       input int hold, input bit noise,
                       output logic [7:0] o, output logic co, output logic ov, output int lat);
    int n;
    n = 0;
    while (!I_READY && n < 50) begin
      tick();
      n++;
    end
    chk1("ready_before_issue", I_READY, 1'b1);
    I0 = a; I1 = b; SUB = s; CIN = c; I_VALID = 1'b1; O_READY = 1'b0;
    tick();
    I_VALID = 1'b0;
    lat = 0;
    while (!O_VALID && lat < 50) begin
      if (noise) scramble();
      tick();
      lat++;
    end
    O_READY = 1'b0;
    o  = O;
    co = COUT;
    ov = OVF;
    for (int k = 0; k < hold; k++) begin
      if (noise) begin
        I0 = 8'($urandom); I1 = 8'($urandom); SUB = 1'($urandom);
        CIN = 1'($urandom); I_VALID = 1'($urandom);
      end
      tick();
      chk8("hold_o", O, o);
      chk1("hold_cout", COUT, co);
      chk1("hold_valid", O_VALID, 1'b1);
      chk1("hold_iready", I_READY, 1'b0);
    end
    I_VALID = 1'b0;
    O_READY = 1'b1;
    tick();
    O_READY = 1'b0;
    chk1("valid_drop", O_VALID, 1'b0);
    chk1("ready_back", I_READY, 1'b1);
  endtask

  initial begin
    logic [7:0] ro, mo;
    logic       rc, rv, mc, mv, seen;
    int         lat;

    vecs[0] = '{8'h05, 8'h03, 1'b0, 1'b0, 8'h08, 1'b0, 1'b0};
    vecs[1] = '{8'h05, 8'h03, 1'b1, 1'b0, 8'h02, 1'b1, 1'b0};
    vecs[2] = '{8'h03, 8'h05, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0};
    vecs[3] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[4] = '{8'hFF, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[5] = '{8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[6] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};

    RESET = 1'b1; I_VALID = 1'b0; O_READY = 1'b0;
    I0 = '0; I1 = '0; SUB = 1'b0; CIN = 1'b0;
    tick();
    tick();
    chk1("rst_iready", I_READY, 1'b0);
    chk1("rst_ovalid", O_VALID, 1'b0);
    RESET = 1'b0;
    #1;
    chk1("post_rst_iready", I_READY, 1'b1);
    chk8("post_rst_o", O, 8'h00);
    chk1("post_rst_cout", COUT, 1'b0);
    chk1("post_rst_ovf", OVF, 1'b0);

    for (int i = 0; i < 7; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, 0, 1'b0, ro, rc, rv, lat);
      $display("vec %0d: %02h %s %02h cin=%0b -> O=%02h COUT=%0b OVF=%0b lat=%0d",
               i, vecs[i].a, vecs[i].sub ? "-" : "+", vecs[i].b, vecs[i].cin, ro, rc, rv, lat);
      chk8("vec_o", ro, vecs[i].o);
      chk1("vec_cout", rc, vecs[i].co);
      chk8("vec_latency", 8'(lat), 8'(W));
`ifdef ADDSUB8_SERIAL_OVF_EN
      chk1("vec_ovf", rv, vecs[i].ov);
`endif
    end

    // Backpressure with input noise while the result is held.
    do_op(8'h5A, 8'h33, 1'b0, 1'b0, 5, 1'b1, ro, rc, rv, lat);
    $display("backpressure: O=%02h COUT=%0b lat=%0d", ro, rc, lat);
    chk8("bp_o", ro, 8'h8D);
    chk1("bp_cout", rc, 1'b0);

    // Reset during the 4th BUSY cycle abandons the operation.
    I0 = 8'hAA; I1 = 8'h55; SUB = 1'b0; CIN = 1'b1; I_VALID = 1'b1;
    tick();
    I_VALID = 1'b0;
    tick();
    tick();
    tick();
    RESET = 1'b1;
    #1;
    chk1("midrst_iready_in_reset", I_READY, 1'b0);
    tick();
    chk1("midrst_ovalid", O_VALID, 1'b0);
    chk8("midrst_o", O, 8'h00);
    chk1("midrst_cout", COUT, 1'b0);
    RESET = 1'b0;
    #1;
    chk1("midrst_iready", I_READY, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      seen = seen | O_VALID;
    end
    chk1("midrst_no_result", seen, 1'b0);
    $display("mid-busy reset: O_VALID seen afterwards=%0b", seen);
    do_op(8'h10, 8'h20, 1'b0, 1'b0, 0, 1'b0, ro, rc, rv, lat);
    $display("after reset: 10+20 -> O=%02h COUT=%0b", ro, rc);
    chk8("after_rst_o", ro, 8'h30);
    chk1("after_rst_cout", rc, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      logic [7:0] a, b;
      logic       s, c;
      a = 8'($urandom);
      b = 8'($urandom);
      s = 1'($urandom);
      c = 1'($urandom);
      do_op(a, b, s, c, int'($urandom_range(0, 3)), 1'b1, ro, rc, rv, lat);
      model(a, b, s, c, mo, mc, mv);
      $display("rand %0d: %02h %s %02h cin=%0b -> O=%02h COUT=%0b OVF=%0b", i, a, s ? "-" : "+", b, c, ro, rc, rv);
      chk8("rand_o", ro, mo);
      chk1("rand_cout", rc, mc);
      chk8("rand_latency", 8'(lat), 8'(W));
`ifdef ADDSUB8_SERIAL_OVF_EN
      chk1("rand_ovf", rv, mv);
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
